ibex_fp_wb_arbiter: RTL and testbench

Write-back stage directly upstream of the 3-read/1-write FF register file. It merges load results from the LSU and variable-latency FPU results onto the single write port (waddr_a/wdata_a/we_a). FPU results are buffered in a small FIFO and accepted through a valid/ready handshake. A per-register busy scoreboard tracks outstanding FPU writes so the ID stage can stall on hazards.

---
 rtl/ibex_fp_wb_arbiter_if.sv | 36 +++
 rtl/ibex_fp_wb_arbiter.sv | 117 +++++++++++
 tb/tb_ibex_fp_wb_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ibex_fp_wb_arbiter_if.sv
// Write-back bus between LSU/FPU producers, the ID-stage scoreboard consumer and the register file.
// The arbiter takes the slave modport; the environment driving it takes master.
interface ibex_fp_wb_arbiter_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 2,
  parameter int unsigned NumRegs   = 32
);
  logic                         lsu_valid_i;
  logic [4:0]                   lsu_waddr_i;
  logic [DataWidth-1:0]         lsu_wdata_i;
  logic                         fpu_valid_i;
  logic                         fpu_ready_o;
  logic [4:0]                   fpu_waddr_i;
  logic [DataWidth-1:0]         fpu_wdata_i;
  logic                         issue_valid_i;
  logic [4:0]                   issue_waddr_i;
  logic [4:0]                   waddr_a_o;
  logic [DataWidth-1:0]         wdata_a_o;
  logic                         we_a_o;
  logic [NumRegs-1:0]           busy_o;
  logic [$clog2(FifoDepth):0]   fifo_count_o;

  modport slave (
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  fpu_valid_i, fpu_waddr_i, fpu_wdata_i,
    input  issue_valid_i, issue_waddr_i,
    output fpu_ready_o, waddr_a_o, wdata_a_o, we_a_o, busy_o, fifo_count_o
  );

  modport master (
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output fpu_valid_i, fpu_waddr_i, fpu_wdata_i,
    output issue_valid_i, issue_waddr_i,
    input  fpu_ready_o, waddr_a_o, wdata_a_o, we_a_o, busy_o, fifo_count_o
  );
endinterface

// File: rtl/ibex_fp_wb_arbiter.sv
// Merges LSU loads and buffered FPU results onto the single register-file write port and keeps
// a busy scoreboard of outstanding FPU writes. Define FP_WB_BYPASS_EN to let FPU results skip an empty FIFO.
module ibex_fp_wb_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 2,
  parameter int unsigned NumRegs   = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  ibex_fp_wb_arbiter_if.slave bus
);

  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned AddrW = 5;

  logic [AddrW-1:0]     r_mem_addr [FifoDepth];
  logic [DataWidth-1:0] r_mem_data [FifoDepth];
  logic [PtrW-1:0]      r_head, r_tail;
  logic [CntW-1:0]      r_count, w_count_d;
  logic                 r_we, w_we_d;
  logic [AddrW-1:0]     r_waddr, w_waddr_d;
  logic [DataWidth-1:0] r_wdata, w_wdata_d;
  logic [NumRegs-1:0]   r_busy, w_busy_d;

  logic w_full, w_empty, w_hs, w_bypass, w_push, w_pop, w_fpu_commit;

  always_comb begin
    w_full   = (r_count == CntW'(FifoDepth));
    w_empty  = (r_count == '0);
    w_hs     = bus.fpu_valid_i & ~w_full;
`ifdef FP_WB_BYPASS_EN
    w_bypass = w_hs & w_empty & ~bus.lsu_valid_i;
`else
    w_bypass = 1'b0;
`endif
    w_push   = w_hs & ~w_bypass;
    w_pop    = ~bus.lsu_valid_i & ~w_empty;
  end

  // Fixed priority: LSU, then FIFO head, then (optionally) a bypassed FPU result.
  always_comb begin
    w_we_d       = 1'b0;
    w_waddr_d    = r_waddr;
    w_wdata_d    = r_wdata;
    w_fpu_commit = 1'b0;
    if (bus.lsu_valid_i) begin
      w_waddr_d = bus.lsu_waddr_i;
      w_wdata_d = bus.lsu_wdata_i;
      w_we_d    = (bus.lsu_waddr_i != '0);
    end else if (w_pop) begin
      w_waddr_d    = r_mem_addr[r_head];
      w_wdata_d    = r_mem_data[r_head];
      w_we_d       = (r_mem_addr[r_head] != '0);
      w_fpu_commit = 1'b1;
    end else if (w_bypass) begin
      w_waddr_d    = bus.fpu_waddr_i;
      w_wdata_d    = bus.fpu_wdata_i;
      w_we_d       = (bus.fpu_waddr_i != '0);
      w_fpu_commit = 1'b1;
    end
  end

  // Clear before set so a same-cycle issue to the committing register keeps it busy.
  always_comb begin
    w_busy_d = r_busy;
    for (int i = 1; i < int'(NumRegs); i++) begin
      if (w_fpu_commit && (w_waddr_d == AddrW'(i))) w_busy_d[i] = 1'b0;
      if (bus.issue_valid_i && (bus.issue_waddr_i == AddrW'(i))) w_busy_d[i] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  always_comb begin
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CntW'(1);
      2'b01:   w_count_d = r_count - CntW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
    end else begin
      if (w_pop)  r_head <= r_head + PtrW'(1);
      if (w_push) r_tail <= r_tail + PtrW'(1);
      r_count <= w_count_d;
      r_we    <= w_we_d;
      r_waddr <= w_waddr_d;
      r_wdata <= w_wdata_d;
      r_busy  <= w_busy_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count alone.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_addr[r_tail] <= bus.fpu_waddr_i;
      r_mem_data[r_tail] <= bus.fpu_wdata_i;
    end
  end

  assign bus.fpu_ready_o  = ~w_full;
  assign bus.we_a_o       = r_we;
  assign bus.waddr_a_o    = r_waddr;
  assign bus.wdata_a_o    = r_wdata;
  assign bus.busy_o       = r_busy;
  assign bus.fifo_count_o = r_count;

endmodule

// File: tb/tb_ibex_fp_wb_arbiter.sv
// Directed bench for ibex_fp_wb_arbiter; expected values are hand-derived per scenario.
module tb_ibex_fp_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  ibex_fp_wb_arbiter_if bus ();

  ibex_fp_wb_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.lsu_valid_i   = 1'b0;
    bus.fpu_valid_i   = 1'b0;
    bus.issue_valid_i = 1'b0;
  endtask

  task automatic lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.lsu_valid_i = v;
    bus.lsu_waddr_i = a;
    bus.lsu_wdata_i = d;
  endtask

  task automatic fpu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.fpu_valid_i = v;
    bus.fpu_waddr_i = a;
    bus.fpu_wdata_i = d;
  endtask

  task automatic issue(input logic v, input logic [4:0] a);
    bus.issue_valid_i = v;
    bus.issue_waddr_i = a;
  endtask

  task automatic test_reset();
    idle();
    lsu(1'b0, 5'd0, 32'd0);
    fpu(1'b0, 5'd0, 32'd0);
    issue(1'b0, 5'd0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_vec++; if (bus.fifo_count_o !== 2'd0) begin n_miss++; $display("FAIL reset_count got %0d want 0", bus.fifo_count_o); end
    n_vec++; if (bus.fpu_ready_o !== 1'b1) begin n_miss++; $display("FAIL reset_ready got %b want 1", bus.fpu_ready_o); end
    n_vec++; if (bus.we_a_o !== 1'b0) begin n_miss++; $display("FAIL reset_we got %b want 0", bus.we_a_o); end
    n_vec++; if (bus.waddr_a_o !== 5'd0 || bus.wdata_a_o !== 32'd0) begin n_miss++; $display("FAIL reset_wport got %0d/%h want 0/0", bus.waddr_a_o, bus.wdata_a_o); end
    n_vec++; if (bus.busy_o !== 32'd0) begin n_miss++; $display("FAIL reset_busy got %h want 0", bus.busy_o); end
  endtask

  task automatic test_lsu();
    lsu(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    lsu(1'b0, 5'd0, 32'd0);
    n_vec++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_miss++; $display("FAIL lsu_write got we=%b a=%0d d=%h want 1/5/deadbeef", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o); end
    step();
    n_vec++; if (bus.we_a_o !== 1'b0) begin n_miss++; $display("FAIL lsu_one_cycle got we=%b want 0", bus.we_a_o); end
  endtask

  task automatic test_fpu_latency();
    issue(1'b1, 5'd3);
    step();
    issue(1'b0, 5'd0);
    n_vec++; if (bus.busy_o !== 32'h8) begin n_miss++; $display("FAIL issue_busy got %h want 8", bus.busy_o); end
    fpu(1'b1, 5'd3, 32'h3F800000);
    step();
    fpu(1'b0, 5'd0, 32'd0);
`ifdef FP_WB_BYPASS_EN
    n_vec++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd3, 32'h3F800000}) begin
      n_miss++; $display("FAIL fpu_bypass got we=%b a=%0d d=%h want 1/3/3f800000", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o); end
    n_vec++; if (bus.fifo_count_o !== 2'd0 || bus.busy_o !== 32'd0) begin
      n_miss++; $display("FAIL fpu_bypass_state got cnt=%0d busy=%h want 0/0", bus.fifo_count_o, bus.busy_o); end
`else
    n_vec++; if (bus.we_a_o !== 1'b0 || bus.fifo_count_o !== 2'd1 || bus.busy_o !== 32'h8) begin
      n_miss++; $display("FAIL fpu_pushed got we=%b cnt=%0d busy=%h want 0/1/8", bus.we_a_o, bus.fifo_count_o, bus.busy_o); end
    step();
    n_vec++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd3, 32'h3F800000}) begin
      n_miss++; $display("FAIL fpu_pop got we=%b a=%0d d=%h want 1/3/3f800000", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o); end
    n_vec++; if (bus.fifo_count_o !== 2'd0 || bus.busy_o !== 32'd0) begin
      n_miss++; $display("FAIL fpu_pop_state got cnt=%0d busy=%h want 0/0", bus.fifo_count_o, bus.busy_o); end
`endif
    step();
    n_vec++; if (bus.we_a_o !== 1'b0) begin n_miss++; $display("FAIL fpu_one_cycle got we=%b want 0", bus.we_a_o); end
  endtask

  task automatic test_fill_priority();
    lsu(1'b1, 5'd10, 32'hA0); fpu(1'b1, 5'd20, 32'hF0);
    step();
    n_vec++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd10, 32'hA0} || bus.fifo_count_o !== 2'd1) begin
      n_miss++; $display("FAIL fill_lsu0 got we=%b a=%0d d=%h cnt=%0d want 1/10/a0/1", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o, bus.fifo_count_o); end
    lsu(1'b1, 5'd11, 32'hA1); fpu(1'b1, 5'd21, 32'hF1);
    step();
    n_vec++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd11, 32'hA1} || bus.fifo_count_o !== 2'd2) begin
      n_miss++; $display("FAIL fill_lsu1 got we=%b a=%0d d=%h cnt=%0d want 1/11/a1/2", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o, bus.fifo_count_o); end
    n_vec++; if (bus.fpu_ready_o !== 1'b0) begin n_miss++; $display("FAIL full_ready got %b want 0", bus.fpu_ready_o); end
    // Held FPU request while full must not be accepted.
    lsu(1'b1, 5'd12, 32'hA2); fpu(1'b1, 5'd22, 32'hF2);
    step();
    n_vec++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd12, 32'hA2} || bus.fifo_count_o !== 2'd2) begin
      n_miss++; $display("FAIL fill_lsu2 got we=%b a=%0d d=%h cnt=%0d want 1/12/a2/2", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o, bus.fifo_count_o); end
    lsu(1'b0, 5'd0, 32'd0);
    step();
    n_vec++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd20, 32'hF0} || bus.fifo_count_o !== 2'd1) begin
      n_miss++; $display("FAIL pop_first got we=%b a=%0d d=%h cnt=%0d want 1/20/f0/1 (full refuses push in pop cycle)", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o, bus.fifo_count_o); end
    n_vec++; if (bus.fpu_ready_o !== 1'b1) begin n_miss++; $display("FAIL ready_after_pop got %b want 1", bus.fpu_ready_o); end
    fpu(1'b0, 5'd0, 32'd0);
    step();
    n_vec++; if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd21, 32'hF1} || bus.fifo_count_o !== 2'd0) begin
      n_miss++; $display("FAIL pop_second got we=%b a=%0d d=%h cnt=%0d want 1/21/f1/0", bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o, bus.fifo_count_o); end
    step();
    n_vec++; if (bus.we_a_o !== 1'b0) begin n_miss++; $display("FAIL drain_idle got we=%b want 0", bus.we_a_o); end
  endtask

  task automatic test_x0();
    fpu(1'b1, 5'd0, 32'h55);
    step();
    fpu(1'b0, 5'd0, 32'd0);
`ifndef FP_WB_BYPASS_EN
    n_vec++; if (bus.fifo_count_o !== 2'd1) begin n_miss++; $display("FAIL x0_push got cnt=%0d want 1", bus.fifo_count_o); end
    step();
`endif
    n_vec++; if (bus.we_a_o !== 1'b0 || bus.wdata_a_o !== 32'h55 || bus.fifo_count_o !== 2'd0) begin
      n_miss++; $display("FAIL x0_fpu got we=%b d=%h cnt=%0d want 0/55/0", bus.we_a_o, bus.wdata_a_o, bus.fifo_count_o); end
    lsu(1'b1, 5'd0, 32'h77);
    step();
    lsu(1'b0, 5'd0, 32'd0);
    n_vec++; if (bus.we_a_o !== 1'b0 || bus.wdata_a_o !== 32'h77) begin
      n_miss++; $display("FAIL x0_lsu got we=%b d=%h want 0/77", bus.we_a_o, bus.wdata_a_o); end
  endtask

  task automatic test_set_clear();
    issue(1'b1, 5'd7);
    step();
    issue(1'b0, 5'd0);
    fpu(1'b1, 5'd7, 32'h7);
`ifndef FP_WB_BYPASS_EN
    step();
    fpu(1'b0, 5'd0, 32'd0);
`endif
    issue(1'b1, 5'd7);
    step();
    issue(1'b0, 5'd0);
    fpu(1'b0, 5'd0, 32'd0);
    n_vec++; if (bus.we_a_o !== 1'b1 || bus.waddr_a_o !== 5'd7 || bus.busy_o !== 32'h80) begin
      n_miss++; $display("FAIL set_wins got we=%b a=%0d busy=%h want 1/7/80", bus.we_a_o, bus.waddr_a_o, bus.busy_o); end
    fpu(1'b1, 5'd7, 32'h8);
    step();
    fpu(1'b0, 5'd0, 32'd0);
`ifndef FP_WB_BYPASS_EN
    step();
`endif
    n_vec++; if (bus.busy_o !== 32'd0 || bus.wdata_a_o !== 32'h8) begin
      n_miss++; $display("FAIL busy_clear got busy=%h d=%h want 0/8", bus.busy_o, bus.wdata_a_o); end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 5'd1);
    step();
    issue(1'b1, 5'd2);
    lsu(1'b1, 5'd9, 32'h9); fpu(1'b1, 5'd1, 32'h11);
    step();
    issue(1'b0, 5'd0);
    fpu(1'b1, 5'd2, 32'h22);
    step();
    fpu(1'b0, 5'd0, 32'd0);
    n_vec++; if (bus.fifo_count_o !== 2'd2 || bus.busy_o !== 32'h6) begin
      n_miss++; $display("FAIL prereset got cnt=%0d busy=%h want 2/6", bus.fifo_count_o, bus.busy_o); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus.fifo_count_o !== 2'd0 || bus.busy_o !== 32'd0 || bus.we_a_o !== 1'b0) begin
      n_miss++; $display("FAIL async_reset got cnt=%0d busy=%h we=%b want 0/0/0", bus.fifo_count_o, bus.busy_o, bus.we_a_o); end
    lsu(1'b0, 5'd0, 32'd0);
    step();
    rst = 1'b0;
    step();
    n_vec++; if (bus.fpu_ready_o !== 1'b1 || bus.fifo_count_o !== 2'd0) begin
      n_miss++; $display("FAIL post_reset got ready=%b cnt=%0d want 1/0", bus.fpu_ready_o, bus.fifo_count_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (bus.we_a_o !== 1'b0) begin n_miss++; $display("FAIL post_reset_nowrite[%0d] got we=%b want 0", i, bus.we_a_o); end
    end
  endtask

  initial begin
    test_reset();
    test_lsu();
    test_fpu_latency();
    test_fill_priority();
    test_x0();
    test_set_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
